// File: rtl/ptp_cfg_pkg.sv
// Shared definitions for the PTP RTC configuration sequencer: register map,
// sequence step and FSM state encodings, and the per-step write data helpers.
package ptp_cfg_pkg;

    localparam logic [3:0] TSU_BLK  = 4'h1;
    localparam logic [3:0] RTC_BLK  = 4'h2;

    localparam logic [3:0] TSU_CFG  = 4'h0;
    localparam logic [3:0] TICK_INC = 4'h0;
    localparam logic [3:0] NS_OFST  = 4'h1;
    localparam logic [3:0] SC_OFST0 = 4'h2;
    localparam logic [3:0] SC_OFST1 = 4'h3;
    localparam logic [3:0] RTC_CTL  = 4'h4;

    localparam logic [7:0] A_TSU_CFG  = {TSU_BLK, TSU_CFG};
    localparam logic [7:0] A_TICK_INC = {RTC_BLK, TICK_INC};
    localparam logic [7:0] A_NS_OFST  = {RTC_BLK, NS_OFST};
    localparam logic [7:0] A_SC_OFST0 = {RTC_BLK, SC_OFST0};
    localparam logic [7:0] A_SC_OFST1 = {RTC_BLK, SC_OFST1};
    localparam logic [7:0] A_RTC_CTL  = {RTC_BLK, RTC_CTL};

    localparam logic [31:0] HOST_TIMEOUT_RDATA = 32'hdead_beef;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOST,
        ST_SEQ_WR,
        ST_SEQ_GAP
    } state_e;

    typedef enum logic [2:0] {
        STEP_TSU_CFG  = 3'd0,
        STEP_TICK_INC = 3'd1,
        STEP_NS_OFST  = 3'd2,
        STEP_SC_OFST0 = 3'd3,
        STEP_SC_OFST1 = 3'd4,
        STEP_RTC_CTL  = 3'd5
    } step_e;

    typedef struct packed {
        logic [5:0]  clk_ctl;
        logic [31:0] tick_inc;
        logic [31:0] ns_ofst;
        logic [47:0] sc_ofst;
        logic        load_time;
    } seq_cfg_t;

    function automatic logic [7:0] step_addr(input step_e s);
        logic [7:0] a;
        case (s)
            STEP_TSU_CFG:  a = A_TSU_CFG;
            STEP_TICK_INC: a = A_TICK_INC;
            STEP_NS_OFST:  a = A_NS_OFST;
            STEP_SC_OFST0: a = A_SC_OFST0;
            STEP_SC_OFST1: a = A_SC_OFST1;
            STEP_RTC_CTL:  a = A_RTC_CTL;
            default:       a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] step_data(input step_e s, input seq_cfg_t c);
        logic [31:0] d;
        case (s)
            STEP_TSU_CFG:  d = {26'b0, c.clk_ctl};
            STEP_TICK_INC: d = c.tick_inc;
            STEP_NS_OFST:  d = c.ns_ofst;
            STEP_SC_OFST0: d = {16'b0, c.sc_ofst[47:32]};
            STEP_SC_OFST1: d = c.sc_ofst[31:0];
            STEP_RTC_CTL:  d = 32'h1;
            default:       d = 32'h0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ptp_rtc_cfg_sequencer_xfer.sv
// Single-access register bus engine: holds cs/wr/addr/wdata until ack or
// timeout, and reports either outcome combinationally in the final cycle.
module ptp_bus_xfer
    import ptp_cfg_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              bus_ack_i,
    output logic              bus_cs_o,
    output logic              bus_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic              ack_o,
    output logic              timeout_o
);

    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        ack_o     = cs_q & bus_ack_i;
        // Last allowed cycle is the TIMEOUT-th one with cs high; an ack there still wins.
        timeout_o = cs_q & ~bus_ack_i & (cnt_q == TIMEOUT - 16'd1);
        cs_d      = cs_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        if (issue_i) begin
            cs_d    = 1'b1;
            wr_d    = wr_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            cnt_d   = '0;
        end else if (ack_o || timeout_o) begin
            cs_d  = 1'b0;
            cnt_d = '0;
        end else if (cs_q) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_cs_o    = cs_q;
    assign bus_wr_o    = wr_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: rtl/ptp_rtc_cfg_sequencer.sv
// Programs the TSU/RTC registers of one PTP endpoint on request and
// arbitrates the shared register bus against host accesses.
module ptp_rtc_cfg_sequencer
    import ptp_cfg_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              load_time_i,
    input  logic [5:0]        clk_ctl_i,
    input  logic [31:0]       tick_inc_i,
    input  logic [31:0]       ns_ofst_i,
    input  logic [47:0]       sc_ofst_i,
    input  logic              host_req_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [31:0]       host_wdata_i,
    output logic              host_ack_o,
    output logic [31:0]       host_rdata_o,
    output logic              bus_cs_o,
    output logic              bus_wr_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic        pending_q, pending_d;
    seq_cfg_t    cfg_q, cfg_d, cfg_in;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        host_ack_q, host_ack_d;
    logic [31:0] host_rdata_q, host_rdata_d;

    logic              xfer_issue;
    logic              xfer_wr;
    logic [ADDR_W-1:0] xfer_addr;
    logic [31:0]       xfer_wdata;
    logic              xfer_ack;
    logic              xfer_timeout;
    logic              last_step;

    assign cfg_in = '{clk_ctl:   clk_ctl_i,
                      tick_inc:  tick_inc_i,
                      ns_ofst:   ns_ofst_i,
                      sc_ofst:   sc_ofst_i,
                      load_time: load_time_i};

    assign last_step = (step_q == STEP_RTC_CTL) ||
                       ((step_q == STEP_TICK_INC) && !cfg_q.load_time);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pending_d    = pending_q;
        cfg_d        = cfg_q;
        err_d        = err_q;
        done_d       = 1'b0;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        xfer_issue   = 1'b0;
        xfer_wr      = 1'b1;
        xfer_addr    = ADDR_W'(step_addr(step_q));
        xfer_wdata   = step_data(step_q, cfg_q);

        case (state_q)
            ST_IDLE: begin
                if (start_i || pending_q) begin
                    if (start_i) begin
                        cfg_d = cfg_in;
                    end
                    pending_d  = 1'b0;
                    err_d      = 1'b0;
                    step_d     = STEP_TSU_CFG;
                    state_d    = ST_SEQ_WR;
                    xfer_issue = 1'b1;
                    xfer_addr  = ADDR_W'(step_addr(STEP_TSU_CFG));
                    xfer_wdata = step_data(STEP_TSU_CFG, cfg_d);
                // The host still holds req during its ack cycle; don't re-serve it.
                end else if (host_req_i && !host_ack_q) begin
                    state_d    = ST_HOST;
                    xfer_issue = 1'b1;
                    xfer_wr    = host_wr_i;
                    xfer_addr  = host_addr_i;
                    xfer_wdata = host_wdata_i;
                end
            end

            ST_HOST: begin
                if (start_i) begin
                    pending_d = 1'b1;
                    cfg_d     = cfg_in;
                end
                if (xfer_ack) begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = bus_rdata_i;
                    state_d      = ST_IDLE;
                end else if (xfer_timeout) begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = HOST_TIMEOUT_RDATA;
                    err_d        = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            ST_SEQ_WR: begin
                if (xfer_ack) begin
                    if (last_step) begin
                        done_d  = 1'b1;
                        step_d  = STEP_TSU_CFG;
                        state_d = ST_IDLE;
                    end else begin
                        step_d  = step_e'(step_q + 3'd1);
                        state_d = ST_SEQ_GAP;
                    end
                end else if (xfer_timeout) begin
                    err_d   = 1'b1;
                    step_d  = STEP_TSU_CFG;
                    state_d = ST_IDLE;
                end
            end

            ST_SEQ_GAP: begin
                xfer_issue = 1'b1;
                state_d    = ST_SEQ_WR;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            step_q       <= STEP_TSU_CFG;
            pending_q    <= 1'b0;
            cfg_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            pending_q    <= pending_d;
            cfg_q        <= cfg_d;
            err_q        <= err_d;
            done_q       <= done_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    ptp_bus_xfer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (xfer_issue),
        .wr_i        (xfer_wr),
        .addr_i      (xfer_addr),
        .wdata_i     (xfer_wdata),
        .bus_ack_i   (bus_ack_i),
        .bus_cs_o    (bus_cs_o),
        .bus_wr_o    (bus_wr_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .ack_o       (xfer_ack),
        .timeout_o   (xfer_timeout)
    );

    assign busy_o       = pending_q || (state_q == ST_SEQ_WR) || (state_q == ST_SEQ_GAP);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign host_ack_o   = host_ack_q;
    assign host_rdata_o = host_rdata_q;

endmodule
